// File: rtl/serial_par_mult.sv
// Bit-serial shift-and-add multiplier: A shifted in serially, B written by bit address,
// product built over W cycles. Define MULT_ACC_EN to add the CLR input and running ACC output.
module serial_par_mult #(
  parameter int W  = 4,
  parameter int AW = $clog2(W)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            A_IN,
  input  logic            A_VLD,
  input  logic            B_IN,
  input  logic            B_WE,
  input  logic [AW-1:0]   B_ADDR,
  input  logic            START,
`ifdef MULT_ACC_EN
  input  logic            CLR,
  output logic [2*W+3:0]  ACC,
`endif
  output logic            BUSY,
  output logic [2*W-1:0]  P,
  output logic            P_VLD,
  output logic [W-1:0]    PP
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [2*W-1:0]   sum_q, sum_d, p_q, p_d;
  logic [AW-1:0]    k_q, k_d;
  logic             p_vld_q, p_vld_d;
  logic [2*W-1:0]   b_ext, term;

  assign b_ext = {{W{1'b0}}, b_q};
  assign term  = a_q[k_q] ? (b_ext << k_q) : '0;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    k_d     = k_q;
    p_d     = p_q;
    p_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Operand updates and START on one edge all land; the multiply sees the new values
        if (A_VLD) a_d = {a_q[W-2:0], A_IN};
        if (B_WE && (32'(B_ADDR) < W)) b_d[B_ADDR] = B_IN;
        if (START) begin
          state_d = CALC;
          sum_d   = '0;
          k_d     = '0;
        end
      end
      CALC: begin
        sum_d = sum_q + term;
        k_d   = k_q + AW'(1);
        if (k_q == AW'(W-1)) begin
          state_d = DONE;
          p_d     = sum_q + term;
          p_vld_d = 1'b1;
          k_d     = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
    end
  end

`ifdef MULT_ACC_EN
  logic [2*W+3:0] acc_tot_q, acc_tot_d;

  // P is already the fresh product while in DONE, so the running total adds it on DONE's exit edge
  always_comb begin
    acc_tot_d = acc_tot_q;
    if (state_q == DONE) acc_tot_d = CLR ? {4'b0, p_q} : acc_tot_q + {4'b0, p_q};
    else if (CLR)        acc_tot_d = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) acc_tot_q <= '0;
    else      acc_tot_q <= acc_tot_d;
  end

  assign ACC = acc_tot_q;
`endif

  assign BUSY  = (state_q != IDLE);
  assign P     = p_q;
  assign P_VLD = p_vld_q;
  assign PP    = a_q & b_q;

endmodule
